// File: rtl/key_mode_sequencer.sv
// Debounced KEY0/KEY1 -> MODE[1:0] step sequencer (wraps mod 4); optional hold auto-repeat under KEY_AUTOREPEAT_EN.
// Latency: MODE moves DEBOUNCE_CYCLES+3 edges after a clean press; no flow control, outputs are plain registered levels.
module key_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  output logic [1:0] MODE,
  output logic       MODE_CHG,
  output logic [1:0] KEY_STATE
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            stable_q, stable_d;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]            press_q, press_d;
  logic [1:0]            mode_q, mode_d;
  logic                  mode_chg_q, mode_chg_d;
  logic                  step_up, step_dn;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic [1:0]       rep_q, rep_d;
  logic             one_held;
`endif

  // Stable levels are raw (active-low); a press event is an accepted transition to 0.
  always_comb begin
    sync1_d  = KEY;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    press_d  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          stable_d[k] = sync2_q[k];
          db_cnt_d[k] = '0;
          press_d[k]  = ~sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + CNT_W'(1);
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
  always_comb begin
    one_held    = (stable_q == 2'b10) || (stable_q == 2'b01);
    rep_d       = 2'b00;
    hold_cnt_d  = '0;
    rep_phase_d = 1'b0;
    if (one_held && (press_d == 2'b00)) begin
      if (hold_cnt_q == (rep_phase_q ? RP_LAST : RD_LAST)) begin
        rep_d       = ~stable_q;
        rep_phase_d = 1'b1;
      end else begin
        hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        rep_phase_d = rep_phase_q;
      end
    end
  end

  assign step_up = press_q[0] | rep_q[0];
  assign step_dn = press_q[1] | rep_q[1];
`else
  assign step_up = press_q[0];
  assign step_dn = press_q[1];
`endif

  always_comb begin
    mode_d = mode_q;
    if (step_up && !step_dn) begin
      mode_d = mode_q + 2'd1;
    end else if (step_dn && !step_up) begin
      mode_d = mode_q - 2'd1;
    end
    mode_chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      stable_q    <= 2'b11;
      db_cnt_q    <= '0;
      press_q     <= 2'b00;
      mode_q      <= 2'd0;
      mode_chg_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
      rep_q       <= 2'b00;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      mode_q      <= mode_d;
      mode_chg_q  <= mode_chg_d;
`ifdef KEY_AUTOREPEAT_EN
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
      rep_q       <= rep_d;
`endif
    end
  end

  assign MODE      = mode_q;
  assign MODE_CHG  = mode_chg_q;
  assign KEY_STATE = ~stable_q;

endmodule
